// File: rtl/tlc_pkg.sv
// Shared definitions for the intersection controller: state encodings,
// state_o width and the approach one-hot decode helper.
package tlc_pkg;

    localparam int STATE_W = 3;
    localparam int MAX_DIR = 8;

    typedef logic [STATE_W-1:0] tlc_state_t;

    localparam tlc_state_t ST_ALL_RED    = 3'd0;
    localparam tlc_state_t ST_RED_YELLOW = 3'd1;
    localparam tlc_state_t ST_GREEN      = 3'd2;
    localparam tlc_state_t ST_YELLOW     = 3'd3;
    localparam tlc_state_t ST_EMERGENCY  = 3'd4;

    // One-hot decode of an approach index; callers slice to NUM_DIR bits.
    function automatic logic [MAX_DIR-1:0] dir_onehot(input logic [2:0] dir);
        logic [MAX_DIR-1:0] oh;
        oh      = '0;
        oh[dir] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin search: first requesting approach strictly after
// active_dir, wrapping modulo NUM_DIR (active_dir itself is checked last).
module rr_next_dir #(
    parameter int NUM_DIR = 2,
    parameter int DW      = 1
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [DW-1:0]      active_dir,
    output logic [DW-1:0]      next_dir,
    output logic               any_req
);

    logic [NUM_DIR-1:0] rot;
    int                 sh;
    int                 pick;

    // Rotate req so bit 0 is the approach after active_dir, then take the lowest set bit.
    always_comb begin
        sh   = int'(active_dir) + 1;
        rot  = NUM_DIR'({req, req} >> sh);
        pick = 0;
        for (int k = NUM_DIR - 1; k >= 0; k--) begin
            if (rot[k]) pick = k;
        end
        pick = int'(active_dir) + 1 + pick;
        if (pick >= NUM_DIR) pick = pick - NUM_DIR;
        next_dir = DW'(pick);
        any_req  = |req;
    end

endmodule

// File: rtl/intersection_controller.sv
// Multi-approach traffic-light controller with demand latching, min/max green,
// round-robin approach selection and an emergency all-red mode.
// Optional: define TLC_FLASH_EN to flash all yellows in EMERGENCY instead of
// holding steady all red.
module intersection_controller
    import tlc_pkg::*;
#(
    parameter int NUM_DIR     = 2,
    parameter int TW          = 8,
    parameter int CLEAR_TIME  = 4,
    parameter int RY_TIME     = 5,
    parameter int GREEN_MIN   = 10,
    parameter int GREEN_MAX   = 30,
    parameter int YELLOW_TIME = 10,
    parameter int FLASH_HALF  = 8,
    localparam int DW         = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DIR-1:0] sensor,
    input  logic               emergency,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DW-1:0]      active_dir,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [TW-1:0] SAT       = '1;
    localparam logic [TW-1:0] CLR_LAST  = TW'(CLEAR_TIME - 1);
    localparam logic [TW-1:0] RY_LAST   = TW'(RY_TIME - 1);
    localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] Y_LAST    = TW'(YELLOW_TIME - 1);

    tlc_state_t         state_q, state_d;
    logic [TW-1:0]      elapsed_q, elapsed_d;
    logic [NUM_DIR-1:0] req_q, req_d;
    logic [DW-1:0]      active_dir_q, active_dir_d;
    logic [MAX_DIR-1:0] oh_full;
    logic [NUM_DIR-1:0] oh;
    logic [DW-1:0]      next_dir;
    logic               any_req;
    logic               competing;
    logic               active_sensor;
    logic               enter_green;

    assign oh_full       = dir_onehot(3'(active_dir_q));
    assign oh            = oh_full[NUM_DIR-1:0];
    assign competing     = |(req_q & ~oh);
    assign active_sensor = |(sensor & oh);
    assign enter_green   = (state_d == ST_GREEN) && (state_q != ST_GREEN);

    rr_next_dir #(.NUM_DIR(NUM_DIR), .DW(DW)) u_rr (
        .req        (req_q),
        .active_dir (active_dir_q),
        .next_dir   (next_dir),
        .any_req    (any_req)
    );

    // Next-state and approach selection; emergency is checked first everywhere.
    always_comb begin
        state_d      = state_q;
        active_dir_d = active_dir_q;
        case (state_q)
            ST_ALL_RED: begin
                if (emergency) begin
                    state_d = ST_EMERGENCY;
                end else if (elapsed_q >= CLR_LAST && any_req) begin
                    state_d      = ST_RED_YELLOW;
                    active_dir_d = next_dir;
                end
            end
            ST_RED_YELLOW: begin
                if (emergency)                 state_d = ST_YELLOW;
                else if (elapsed_q == RY_LAST) state_d = ST_GREEN;
            end
            ST_GREEN: begin
                if (emergency)
                    state_d = ST_YELLOW;
                else if (competing && ((elapsed_q >= GMIN_LAST && !active_sensor) ||
                                       elapsed_q == GMAX_LAST))
                    state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (elapsed_q == Y_LAST) state_d = emergency ? ST_EMERGENCY : ST_ALL_RED;
            end
            ST_EMERGENCY: begin
                if (!emergency) state_d = ST_ALL_RED;
            end
            default: state_d = ST_ALL_RED;
        endcase
    end

    // Cycle timer: clears on any state change; green holds at GREEN_MAX-1.
    always_comb begin
        if (state_d != state_q)
            elapsed_d = '0;
        else if (state_q == ST_GREEN)
            elapsed_d = (elapsed_q >= GMAX_LAST) ? GMAX_LAST : elapsed_q + 1'b1;
        else
            elapsed_d = (elapsed_q == SAT) ? SAT : elapsed_q + 1'b1;
    end

    // Demand latch; the grant clear wins over a same-cycle sensor set.
    always_comb begin
        req_d = req_q | sensor;
        if (enter_green) req_d = req_d & ~oh;
    end

    // Core state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ALL_RED;
            elapsed_q    <= '0;
            req_q        <= '0;
            active_dir_q <= DW'(NUM_DIR - 1);
        end else begin
            state_q      <= state_d;
            elapsed_q    <= elapsed_d;
            req_q        <= req_d;
            active_dir_q <= active_dir_d;
        end
    end

`ifdef TLC_FLASH_EN
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] FL_LAST = FW'(FLASH_HALF - 1);

    logic [FW-1:0] flash_cnt_q;
    logic          flash_on_q;

    // Flash phase counter: restarts lit on entry, toggles every FLASH_HALF cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b0;
        end else if (state_d == ST_EMERGENCY && state_q != ST_EMERGENCY) begin
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b1;
        end else if (state_q == ST_EMERGENCY) begin
            if (flash_cnt_q == FL_LAST) begin
                flash_cnt_q <= '0;
                flash_on_q  <= ~flash_on_q;
            end else begin
                flash_cnt_q <= flash_cnt_q + 1'b1;
            end
        end
    end
`endif

    // Moore lamp decode from registered state and active approach.
    always_comb begin
        red    = '1;
        yellow = '0;
        green  = '0;
        case (state_q)
            ST_RED_YELLOW: yellow = oh;
            ST_GREEN: begin
                red   = ~oh;
                green = oh;
            end
            ST_YELLOW: begin
                red    = ~oh;
                yellow = oh;
            end
`ifdef TLC_FLASH_EN
            ST_EMERGENCY: begin
                red    = '0;
                yellow = {NUM_DIR{flash_on_q}};
            end
`endif
            default: ;
        endcase
    end

    assign active_dir = active_dir_q;
    assign state_o    = state_q;

endmodule
